// File: rtl/fc_layer_par.sv
// fc_layer_par: fully-connected layer y = act(sat((W.x + b) >>> FRAC)) over P parallel MAC lanes.
// Latency: last x accepted to first m_valid is N+3 cycles; each group of P rows then takes N+2 compute cycles.
// Backpressure: s_ready only in LOAD_X; DRAIN holds m_valid/data_out stable while m_ready is low.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   s_valid/s_ready/data_in    input vector stream, one signed T-bit element per transfer
//   m_valid/m_ready/data_out   output stream, rows in ascending order
//   cfg_we/cfg_addr/cfg_data   weight/bias write port; cfg_ready marks cycles where writes land
//                              (address r*N+c = W[r][c], M*N+r = b[r], anything above is dropped)
module fc_layer_par #(
    parameter int M        = 16,
    parameter int N        = 8,
    parameter int T        = 16,
    parameter int P        = 2,
    parameter int FRAC     = 0,
    parameter int ACT_RELU = 1,
    parameter int AW       = $clog2(M*N+M)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [T-1:0] data_in,
    output logic                m_valid,
    input  logic                m_ready,
    output logic signed [T-1:0] data_out,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic signed [T-1:0] cfg_data,
    output logic                cfg_ready
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int G    = M / P;                    // number of row groups
    localparam int NW   = M * N;                    // weight words
    localparam int ACCW = 2*T + $clog2(N+1);        // N products plus bias cannot overflow
    localparam int CW   = $clog2(N+1);              // x count 0..N
    localparam int KW   = $clog2(N+2);              // compute step 0..N+1
    localparam int LW   = (P > 1)  ? $clog2(P)  : 1;
    localparam int GW   = (G > 1)  ? $clog2(G)  : 1;
    localparam int WAW  = (NW > 1) ? $clog2(NW) : 1;
    localparam int BAW  = (M > 1)  ? $clog2(M)  : 1;
    localparam int XAW  = (N > 1)  ? $clog2(N)  : 1;

    localparam logic [CW-1:0] X_LAST   = CW'(N-1);
    localparam logic [KW-1:0] K_LAST   = KW'(N+1);
    localparam logic [LW-1:0] LANE_LAST = LW'(P-1);
    localparam logic [GW-1:0] GRP_LAST = GW'(G-1);

    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'({1'b0, {(T-1){1'b1}}});
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        LOAD_X  = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Storage: weights, bias and the current x vector. These are never
    // reset so a loaded configuration survives a pipeline reset.
    // ------------------------------------------------------------------
    logic signed [T-1:0] w_mem [NW];
    logic signed [T-1:0] b_mem [M];
    logic signed [T-1:0] x_mem [N];

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;   // x elements accepted
    logic [KW-1:0]   kcnt_q,  kcnt_d;    // step within COMPUTE
    logic [LW-1:0]   lane_q,  lane_d;    // lane being drained
    logic [GW-1:0]   grp_q,   grp_d;     // current row group

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic signed [T-1:0]    w_rd_q [P];
    logic signed [T-1:0]    x_rd_q;
    logic signed [ACCW-1:0] acc_q  [P];
    logic signed [T-1:0]    obuf_q [P];
    logic signed [2*T-1:0]  prod   [P];

    logic x_fire;
    logic m_fire;
    logic cfg_w_en;
    logic cfg_b_en;
    logic [WAW-1:0] cfg_w_idx;
    logic [BAW-1:0] cfg_b_idx;
    int             rd_col;

    // ------------------------------------------------------------------
    // Handshake outputs are pure functions of state
    // ------------------------------------------------------------------
    assign s_ready   = (state_q == LOAD_X);
    assign m_valid   = (state_q == DRAIN);
    assign cfg_ready = (state_q == LOAD_X) && (count_q == '0);
    assign data_out  = (state_q == DRAIN) ? obuf_q[lane_q] : '0;

    assign x_fire = s_valid && s_ready;
    assign m_fire = m_valid && m_ready;

    // Config decode: writes land only in the idle window before the
    // first x element, so a vector never sees a half-updated weight set.
    always_comb begin
        cfg_w_en  = 1'b0;
        cfg_b_en  = 1'b0;
        cfg_w_idx = '0;
        cfg_b_idx = '0;
        if (cfg_we && cfg_ready && !reset) begin
            if (int'(cfg_addr) < NW) begin
                cfg_w_en  = 1'b1;
                cfg_w_idx = WAW'(int'(cfg_addr));
            end else if (int'(cfg_addr) < NW + M) begin
                cfg_b_en  = 1'b1;
                cfg_b_idx = BAW'(int'(cfg_addr) - NW);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_w_en) begin
            w_mem[cfg_w_idx] <= cfg_data;
        end
        if (cfg_b_en) begin
            b_mem[cfg_b_idx] <= cfg_data;
        end
        if (x_fire && !reset) begin
            x_mem[XAW'(count_q)] <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        kcnt_d  = kcnt_q;
        lane_d  = lane_q;
        grp_d   = grp_q;
        case (state_q)
            LOAD_X: begin
                if (x_fire) begin
                    count_d = count_q + 1'b1;
                    if (count_q == X_LAST) begin
                        state_d = COMPUTE;
                        kcnt_d  = '0;
                    end
                end
            end
            COMPUTE: begin
                kcnt_d = kcnt_q + 1'b1;
                if (kcnt_q == K_LAST) begin
                    state_d = DRAIN;
                    lane_d  = '0;
                end
            end
            DRAIN: begin
                if (m_fire) begin
                    if (lane_q == LANE_LAST) begin
                        lane_d = '0;
                        if (grp_q == GRP_LAST) begin
                            grp_d   = '0;
                            count_d = '0;
                            state_d = LOAD_X;
                        end else begin
                            grp_d   = grp_q + 1'b1;
                            kcnt_d  = '0;
                            state_d = COMPUTE;
                        end
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD_X;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD_X;
            count_q <= '0;
            kcnt_q  <= '0;
            lane_q  <= '0;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            kcnt_q  <= kcnt_d;
            lane_q  <= lane_d;
            grp_q   <= grp_d;
        end
    end

    // ------------------------------------------------------------------
    // MAC pipeline.
    // Step 0      : acc <= bias, read column 0
    // Step 1..N   : acc += W*x using the operands read one step earlier
    // Step N+1    : acc is final; result latched into obuf on DRAIN entry
    // ------------------------------------------------------------------
    always_comb begin
        rd_col = (int'(kcnt_q) < N) ? int'(kcnt_q) : 0;
        for (int k = 0; k < P; k++) begin
            prod[k] = (2*T)'(w_rd_q[k]) * (2*T)'(x_rd_q);
        end
    end

    // Shift, saturate to T bits, then optional ReLU.
    function automatic logic signed [T-1:0] post_proc(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] v;
        logic signed [T-1:0]    r;
        v = a >>> FRAC;
        if (v > SAT_MAX) begin
            r = {1'b0, {(T-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            r = {1'b1, {(T-1){1'b0}}};
        end else begin
            r = v[T-1:0];
        end
        if ((ACT_RELU != 0) && r[T-1]) begin
            r = '0;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        x_rd_q <= x_mem[XAW'(rd_col)];
        for (int k = 0; k < P; k++) begin
            // Lane k owns row grp*P + k of the current group.
            w_rd_q[k] <= w_mem[WAW'((int'(grp_q)*P + k)*N + rd_col)];
        end
        if (state_q == COMPUTE) begin
            for (int k = 0; k < P; k++) begin
                if (kcnt_q == '0) begin
                    // Bias enters in product scale, before the FRAC shift.
                    acc_q[k] <= ACCW'(b_mem[BAW'(int'(grp_q)*P + k)]);
                end else if (int'(kcnt_q) <= N) begin
                    acc_q[k] <= acc_q[k] + ACCW'(prod[k]);
                end
                if (kcnt_q == K_LAST) begin
                    obuf_q[k] <= post_proc(acc_q[k]);
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_par.sv
module tb_fc_layer_par;

    localparam int M  = 4;
    localparam int N  = 2;
    localparam int P  = 2;
    localparam int T  = 16;
    localparam int AW = $clog2(M*N+M);
    localparam int NI = 3;   // instances: relu/frac0, identity/frac0, identity/frac8

    logic                clk = 1'b0;
    logic                reset;
    logic                s_valid;
    logic signed [T-1:0] data_in;
    logic                m_ready;
    logic                cfg_we;
    logic [AW-1:0]       cfg_addr;
    logic signed [T-1:0] cfg_data;

    logic [NI-1:0]       s_rdy;
    logic [NI-1:0]       m_vld;
    logic [NI-1:0]       c_rdy;
    logic signed [T-1:0] dout [NI];

    fc_layer_par #(.M(M), .N(N), .T(T), .P(P), .FRAC(0), .ACT_RELU(1)) u0 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_rdy[0]), .data_in(data_in),
        .m_valid(m_vld[0]), .m_ready(m_ready), .data_out(dout[0]),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(c_rdy[0]));

    fc_layer_par #(.M(M), .N(N), .T(T), .P(P), .FRAC(0), .ACT_RELU(0)) u1 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_rdy[1]), .data_in(data_in),
        .m_valid(m_vld[1]), .m_ready(m_ready), .data_out(dout[1]),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(c_rdy[1]));

    fc_layer_par #(.M(M), .N(N), .T(T), .P(P), .FRAC(8), .ACT_RELU(0)) u2 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_rdy[2]), .data_in(data_in),
        .m_valid(m_vld[2]), .m_ready(m_ready), .data_out(dout[2]),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(c_rdy[2]));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int  wm [M][N];
    int  bm [M];
    int  xb [N];
    bit  busy      = 1'b0;
    int  xcnt      = 0;
    int  gap       = 0;
    int  ocnt      = 0;
    bit  after_rst = 1'b0;
    bit  chk_en    = 1'b0;
    int  expq [NI][$];
    int  got  [NI][$];
    int  rmode = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // y = act(sat((W.x + b) >>> frac)) in plain integer arithmetic.
    function automatic int ref_y(input int r, input int inst);
        longint acc;
        int     frac;
        bit     relu;
        frac = (inst == 2) ? 8 : 0;
        relu = (inst == 0);
        acc  = longint'(bm[r]);
        for (int c = 0; c < N; c++) acc += longint'(wm[r][c]) * longint'(xb[c]);
        acc = acc >>> frac;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        if (relu && acc < 0) acc = 0;
        return int'(acc);
    endfunction

    // Per-cycle protocol/data check against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_sr, exp_cr, exp_mv;
            exp_sr = !busy;
            exp_cr = !busy && (xcnt == 0);
            exp_mv = busy && (gap == 0);
            for (int i = 0; i < NI; i++) begin
                chk("s_ready", int'(s_rdy[i]), int'(exp_sr));
                chk("cfg_ready", int'(c_rdy[i]), int'(exp_cr));
                chk("m_valid", int'(m_vld[i]), int'(exp_mv));
                if (after_rst) chk("data_out_reset", int'(dout[i]), 0);
                if (exp_mv) begin
                    if (expq[i].size() > 0) chk("data_out", int'(dout[i]), expq[i][0]);
                    else fail_now("data_out_no_expectation");
                end
            end
            after_rst = 1'b0;
            if (reset) begin
                busy = 1'b0; xcnt = 0; gap = 0; ocnt = 0; after_rst = 1'b1;
                for (int i = 0; i < NI; i++) expq[i].delete();
            end else begin
                if (exp_mv && m_ready) begin
                    for (int i = 0; i < NI; i++) begin
                        got[i].push_back(int'(dout[i]));
                        if (expq[i].size() > 0) void'(expq[i].pop_front());
                    end
                    ocnt++;
                    if (ocnt % P == 0) begin
                        if (ocnt == M) busy = 1'b0;
                        else gap = N + 2;
                    end
                end else if (busy && gap > 0) begin
                    gap--;
                end
                if (exp_cr && cfg_we && int'(cfg_addr) < M*N + M) begin
                    if (int'(cfg_addr) < M*N) wm[int'(cfg_addr) / N][int'(cfg_addr) % N] = int'(cfg_data);
                    else bm[int'(cfg_addr) - M*N] = int'(cfg_data);
                end
                if (exp_sr && s_valid) begin
                    xb[xcnt] = int'(data_in);
                    xcnt++;
                    if (xcnt == N) begin
                        for (int r = 0; r < M; r++)
                            for (int i = 0; i < NI; i++) expq[i].push_back(ref_y(r, i));
                        busy = 1'b1; gap = N + 2; ocnt = 0; xcnt = 0;
                    end
                end
            end
        end
    end

    // m_ready driver: 0 = always ready, 1 = pattern 1,0,0, 2 = random
    initial begin
        int ph;
        ph = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: begin m_ready = (ph == 0); ph = (ph + 1) % 3; end
                2: m_ready = ($urandom_range(3) != 0);
                default: m_ready = 1'b1;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = T'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic load_common();
        int w [M*N];
        int b [M];
        w = '{1, 2, 3, 4, -5, -6, 7, 8};
        b = '{0, 1, 2, -100};
        for (int a = 0; a < M*N; a++) cfg_wr(a, w[a]);
        for (int r = 0; r < M; r++) cfg_wr(M*N + r, b[r]);
    endtask

    task automatic put_x(input int v);
        int n;
        s_valid = 1'b1; data_in = T'(v); n = 0;
        forever begin
            @(negedge clk);
            if (s_rdy[0]) break;
            n++;
            if (n > 300) begin fail_now("s_ready_wait"); break; end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin tick(); n++; end
        if (busy) fail_now("drain_wait");
    endtask

    task automatic clear_got();
        for (int i = 0; i < NI; i++) got[i].delete();
    endtask

    task automatic run_vec(input int a, input int b);
        put_x(a); put_x(b); wait_idle();
    endtask

    task automatic chk_got(input string nm, input int i, input int e0, input int e1,
                           input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        chk({nm, "_count"}, got[i].size(), 4);
        for (int k = 0; k < 4; k++) chk(nm, (got[i].size() > k) ? got[i][k] : -99999, e[k]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset = 1'b1; s_valid = 1'b0; data_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        load_common();

        // Basic vector with latency measurement
        clear_got();
        put_x(1); put_x(1);
        lat = 1;
        forever begin
            @(negedge clk);
            if (m_vld[0] || lat > 50) break;
            lat++;
        end
        chk("latency", lat, 5);
        wait_idle();
        chk_got("basic_relu", 0, 3, 8, 0, 0);
        chk_got("basic_ident", 1, 3, 8, -9, -85);
        chk_got("basic_frac8", 2, 0, 0, -1, -1);

        // Backpressure
        rmode = 1;
        clear_got();
        run_vec(1, 1);
        chk_got("bp_relu", 0, 3, 8, 0, 0);
        chk_got("bp_ident", 1, 3, 8, -9, -85);
        rmode = 0;
        tick();

        // Saturation and shift
        cfg_wr(0, 32767); cfg_wr(1, 32767); cfg_wr(M*N, 0);
        clear_got(); run_vec(32767, 32767);
        chk("sat_pos_relu", (got[0].size() > 0) ? got[0][0] : -99999, 32767);
        chk("sat_pos_ident", (got[1].size() > 0) ? got[1][0] : -99999, 32767);
        cfg_wr(0, -32768); cfg_wr(1, -32768);
        clear_got(); run_vec(32767, 32767);
        chk("sat_neg_ident", (got[1].size() > 0) ? got[1][0] : -99999, -32768);
        chk("sat_neg_relu", (got[0].size() > 0) ? got[0][0] : -99999, 0);
        cfg_wr(0, 256); cfg_wr(1, 0);
        clear_got(); run_vec(512, 0);
        chk("frac8_shift", (got[2].size() > 0) ? got[2][0] : -99999, 512);

        // Config gating
        load_common();
        clear_got();
        put_x(1);
        cfg_we = 1'b1; cfg_addr = '0; cfg_data = 16'sd99;
        @(negedge clk);
        chk("cfg_ready_gated", int'(c_rdy[0]), 0);
        tick();
        cfg_we = 1'b0;
        put_x(1); wait_idle();
        chk("cfg_ignored", (got[0].size() > 0) ? got[0][0] : -99999, 3);
        cfg_wr(0, 99);
        clear_got(); run_vec(1, 1);
        chk("cfg_applied", (got[0].size() > 0) ? got[0][0] : -99999, 101);
        cfg_wr(0, 1);

        // Reset mid-DRAIN
        clear_got();
        put_x(1); put_x(1);
        lat = 0;
        while (got[0].size() < 1 && lat < 100) begin tick(); lat++; end
        if (got[0].size() < 1) fail_now("first_output_wait");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", int'(m_vld[0]), 0);
        chk("rst_s_ready", int'(s_rdy[0]), 1);
        tick();
        clear_got(); run_vec(1, 1);
        chk_got("after_reset", 0, 3, 8, 0, 0);

        // Randomized traffic, config attempts and occasional resets
        rmode = 2;
        for (int c = 0; c < 3000; c++) begin
            s_valid  = ($urandom_range(2) != 0);
            data_in  = ($urandom_range(1) == 0) ? T'(int'($urandom_range(40)) - 20) : T'($urandom);
            cfg_we   = ($urandom_range(3) == 0);
            cfg_addr = AW'($urandom_range(15));
            cfg_data = ($urandom_range(1) == 0) ? T'(int'($urandom_range(40)) - 20) : T'($urandom);
            reset    = ($urandom_range(299) == 0);
            tick();
        end
        s_valid = 1'b0; cfg_we = 1'b0; reset = 1'b0;
        rmode = 0;
        wait_idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
